// File: rtl/lvds_tx_framer_pkg.sv
// Shared constants and types for the LVDS I/Q transmit framer.
// lvds_rx imports the same sync constants.
package lvds_tx_framer_pkg;

  localparam logic [1:0] I_SYNC       = 2'b10;
  localparam logic [1:0] Q_SYNC       = 2'b01;
  localparam int         FRAME_BITS   = 32;
  localparam int         BITS_PER_CLK = 2;
  localparam int         FRAME_CYCLES = FRAME_BITS / BITS_PER_CLK;
  localparam logic [FRAME_BITS-1:0] IDLE_WORD = 32'h0000_0000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tx_state_t;

  // The I sync field sits at the top of the word and the Q sync field at the top of the lower half.
  function automatic logic sync_ok(input logic [FRAME_BITS-1:0] word);
    return (word[FRAME_BITS-1 -: 2] == I_SYNC) && (word[FRAME_BITS/2-1 -: 2] == Q_SYNC);
  endfunction

endpackage

// File: rtl/lvds_tx_framer_iq_sync_fix.sv
// Combinational I/Q sync-field checker/fixer.
// It either forces the sync pattern into the word or passes the word through unchanged.
module iq_sync_fix
  import lvds_tx_framer_pkg::*;
#(
  parameter bit FORCE_SYNC = 1'b1
) (
  input  logic [FRAME_BITS-1:0] word_in,
  output logic [FRAME_BITS-1:0] word_out,
  output logic                  mismatch
);

  // Overwrite or pass through the sync fields and flag a mismatch.
  always_comb begin
    word_out = word_in;
    mismatch = !sync_ok(word_in);
    if (FORCE_SYNC) begin
      word_out[FRAME_BITS-1 -: 2]   = I_SYNC;
      word_out[FRAME_BITS/2-1 -: 2] = Q_SYNC;
    end else begin
      word_out = word_in;
    end
  end

endmodule

// File: rtl/lvds_tx_framer.sv
// Takes 32-bit I/Q words from the TX FIFO and serialises them MSB-first at 2 bits per DDR clock.
// When the FIFO is empty, it sends idle frames and counts underruns.
module lvds_tx_framer
  import lvds_tx_framer_pkg::*;
#(
  parameter bit FORCE_SYNC     = 1'b1,
  parameter int UNDERRUN_CNT_W = 16
) (
  input  logic                      i_ddr_clk,
  input  logic                      i_rst_b,
  input  logic                      i_tx_enable,
  output logic                      o_fifo_pull,
  input  logic [FRAME_BITS-1:0]     i_fifo_data,
  input  logic                      i_fifo_empty,
  output logic [1:0]                o_ddr_data,
  output logic                      o_active,
  output logic                      o_underrun,
  output logic                      o_sync_err,
  output logic [UNDERRUN_CNT_W-1:0] o_underrun_cnt
);

  localparam logic [3:0] CNT_PULL = 4'(FRAME_CYCLES - 3);
  localparam logic [3:0] CNT_LAST = 4'(FRAME_CYCLES - 1);
  localparam logic [UNDERRUN_CNT_W-1:0] URUN_ONE = UNDERRUN_CNT_W'(1);

  tx_state_t                 state_r;
  logic [3:0]                cnt_r;
  logic [FRAME_BITS-3:0]     rest_r;
  logic [1:0]                ddr_r;
  logic                      pull_r;
  logic                      pulled_r;
  logic                      starved_r;
  logic                      active_r;
  logic                      underrun_r;
  logic                      sync_err_r;
  logic [UNDERRUN_CNT_W-1:0] urun_cnt_r;
  logic [FRAME_BITS-1:0]     fixed_word_s;
  logic                      mismatch_s;
  logic                      take_s;

  iq_sync_fix #(.FORCE_SYNC(FORCE_SYNC)) u_sync_fix (
    .word_in  (i_fifo_data),
    .word_out (fixed_word_s),
    .mismatch (mismatch_s)
  );

  assign take_s = i_tx_enable && !i_fifo_empty;

  // Frame sequencer, shifter, FIFO pull and underrun/sync status.
  always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      rest_r     <= '0;
      ddr_r      <= 2'b00;
      pull_r     <= 1'b0;
      pulled_r   <= 1'b0;
      starved_r  <= 1'b0;
      active_r   <= 1'b0;
      underrun_r <= 1'b0;
      sync_err_r <= 1'b0;
      urun_cnt_r <= '0;
    end else begin
      pull_r     <= 1'b0;
      underrun_r <= 1'b0;
      sync_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r     <= 4'd0;
          rest_r    <= '0;
          ddr_r     <= 2'b00;
          pulled_r  <= 1'b0;
          starved_r <= 1'b0;
          if (i_tx_enable) begin
            state_r    <= RUN;
            active_r   <= 1'b1;
            urun_cnt_r <= '0;
          end else begin
            state_r  <= IDLE;
            active_r <= 1'b0;
          end
        end
        RUN: begin
          cnt_r    <= cnt_r + 4'd1;
          active_r <= 1'b1;
          if (cnt_r == CNT_LAST) begin
            pulled_r  <= 1'b0;
            starved_r <= 1'b0;
            // A pulled word always goes out in full, even if enable has since dropped.
            if (pulled_r) begin
              ddr_r      <= fixed_word_s[FRAME_BITS-1 -: 2];
              rest_r     <= fixed_word_s[FRAME_BITS-3:0];
              sync_err_r <= !FORCE_SYNC && mismatch_s;
            end else if (!i_tx_enable) begin
              state_r  <= IDLE;
              active_r <= 1'b0;
              ddr_r    <= 2'b00;
              rest_r   <= '0;
            end else begin
              ddr_r  <= IDLE_WORD[FRAME_BITS-1 -: 2];
              rest_r <= IDLE_WORD[FRAME_BITS-3:0];
              if (starved_r) begin
                underrun_r <= 1'b1;
                if (urun_cnt_r != {UNDERRUN_CNT_W{1'b1}}) begin
                  urun_cnt_r <= urun_cnt_r + URUN_ONE;
                end
              end
            end
          end else begin
            ddr_r  <= rest_r[FRAME_BITS-3 -: 2];
            rest_r <= {rest_r[FRAME_BITS-5:0], 2'b00};
            if (cnt_r == CNT_PULL) begin
              pull_r    <= take_s;
              pulled_r  <= take_s;
              starved_r <= i_tx_enable && i_fifo_empty;
            end
          end
        end
        default: begin
          state_r  <= IDLE;
          active_r <= 1'b0;
          cnt_r    <= 4'd0;
          ddr_r    <= 2'b00;
        end
      endcase
    end
  end

  assign o_fifo_pull    = pull_r;
  assign o_ddr_data     = ddr_r;
  assign o_active       = active_r;
  assign o_underrun     = underrun_r;
  assign o_sync_err     = sync_err_r;
  assign o_underrun_cnt = urun_cnt_r;

endmodule

// File: tb/tb_lvds_tx_framer.sv
// Directed bench: dut_f forces sync (16-bit counter) and dut_p passes words through (2-bit counter).
// Both DUTs share one stimulus stream.
module tb_lvds_tx_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        empty;
  logic [31:0] data;

  logic        pull_f, act_f, ur_f, se_f;
  logic [1:0]  ddr_f;
  logic [15:0] cnt_f;
  logic        pull_p, act_p, ur_p, se_p;
  logic [1:0]  ddr_p;
  logic [1:0]  cnt_p;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lvds_tx_framer #(.FORCE_SYNC(1'b1), .UNDERRUN_CNT_W(16)) dut_f (
    .i_ddr_clk(clk), .i_rst_b(rst_n), .i_tx_enable(en), .o_fifo_pull(pull_f),
    .i_fifo_data(data), .i_fifo_empty(empty), .o_ddr_data(ddr_f), .o_active(act_f),
    .o_underrun(ur_f), .o_sync_err(se_f), .o_underrun_cnt(cnt_f)
  );

  lvds_tx_framer #(.FORCE_SYNC(1'b0), .UNDERRUN_CNT_W(2)) dut_p (
    .i_ddr_clk(clk), .i_rst_b(rst_n), .i_tx_enable(en), .o_fifo_pull(pull_p),
    .i_fifo_data(data), .i_fifo_empty(empty), .o_ddr_data(ddr_p), .o_active(act_p),
    .o_underrun(ur_p), .o_sync_err(se_p), .o_underrun_cnt(cnt_p)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One 16-cycle frame sampled on negedges; models a one-word FIFO that empties on a pull.
  task automatic frame(input int drop_k, input int fill_k, input logic [31:0] fill_word,
                       output logic [31:0] wf, output logic [31:0] wp, output int pull_k,
                       output int n_ur, output int n_sef, output int n_sep, output int n_act);
    wf = 32'h0; wp = 32'h0; pull_k = -1;
    n_ur = 0; n_sef = 0; n_sep = 0; n_act = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      wf = {wf[29:0], ddr_f};
      wp = {wp[29:0], ddr_p};
      n_ur  += int'(ur_f);
      n_sef += int'(se_f);
      n_sep += int'(se_p);
      n_act += int'(act_f);
      if (pull_f) begin
        pull_k = k;
        empty  = 1'b1;
      end
      if (k == drop_k) en = 1'b0;
      if (k == fill_k) begin
        empty = 1'b0;
        data  = fill_word;
      end
    end
  endtask

  task automatic run_frame(input string tag, input int drop_k, input int fill_k,
                           input logic [31:0] fill_word, input logic [31:0] exp_f,
                           input logic [31:0] exp_p, input int exp_pull, input int exp_ur,
                           input int exp_sep, input int exp_act);
    logic [31:0] wf, wp;
    int pull_k, n_ur, n_sef, n_sep, n_act;
    frame(drop_k, fill_k, fill_word, wf, wp, pull_k, n_ur, n_sef, n_sep, n_act);
    check({tag, "_word_f"}, wf, exp_f);
    check({tag, "_word_p"}, wp, exp_p);
    check({tag, "_pull_k"}, pull_k, exp_pull);
    check({tag, "_underruns"}, n_ur, exp_ur);
    check({tag, "_sync_err_p"}, n_sep, exp_sep);
    check({tag, "_sync_err_f"}, n_sef, 32'd0);
    check({tag, "_active_cycles"}, n_act, exp_act);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    empty = 1'b1;
    data  = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_ddr", ddr_f, 2'b00);
    check("rst_pull", pull_f, 1'b0);
    check("rst_active", act_f, 1'b0);
    check("rst_underrun", ur_f, 1'b0);
    check("rst_sync_err", se_p, 1'b0);
    check("rst_cnt", cnt_f, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_enable", act_f, 1'b0);

    en = 1'b1; empty = 1'b0; data = 32'hA5A5_5A5A;
    run_frame("f1_idle", -1, -1, 32'h0, 32'h0, 32'h0, 14, 0, 0, 16);
    run_frame("f2_a5a5", -1, -1, 32'h0, 32'hA5A5_5A5A, 32'hA5A5_5A5A, -1, 0, 0, 16);
    run_frame("f3_ur_fill_late", -1, 14, 32'h0, 32'h0, 32'h0, -1, 1, 0, 16);
    run_frame("f4_ur_again", -1, -1, 32'h0, 32'h0, 32'h0, 14, 1, 0, 16);
    run_frame("f5_zero_word", -1, 3, 32'h8000_4000, 32'h8000_4000, 32'h0, 14, 0, 1, 16);
    run_frame("f6_valid_word", -1, -1, 32'h0, 32'h8000_4000, 32'h8000_4000, -1, 0, 0, 16);
    run_frame("f7_ur", -1, -1, 32'h0, 32'h0, 32'h0, -1, 1, 0, 16);
    check("f7_cnt_f", cnt_f, 16'd3);
    check("f7_cnt_p", cnt_p, 2'd3);
    run_frame("f8_ur", -1, -1, 32'h0, 32'h0, 32'h0, -1, 1, 0, 16);
    check("f8_cnt_f", cnt_f, 16'd4);
    check("f8_cnt_p_sat", cnt_p, 2'd3);
    run_frame("f9_ur", -1, 3, 32'hA5A5_5A5A, 32'h0, 32'h0, 14, 1, 0, 16);
    check("f9_cnt_f", cnt_f, 16'd5);
    check("f9_cnt_p_sat", cnt_p, 2'd3);

    run_frame("f10_drop_k5", 5, 1, 32'h5A5A_A5A5, 32'hA5A5_5A5A, 32'hA5A5_5A5A, -1, 0, 0, 16);
    run_frame("f11_idle_state", -1, -1, 32'h0, 32'h0, 32'h0, -1, 0, 0, 0);
    check("f11_cnt_kept", cnt_f, 16'd5);
    check("f11_fifo_kept", empty, 1'b0);

    en = 1'b1;
    run_frame("f12_restart", -1, -1, 32'h0, 32'h0, 32'h0, 14, 0, 0, 16);
    check("f12_cnt_cleared_f", cnt_f, 16'd0);
    check("f12_cnt_cleared_p", cnt_p, 2'd0);

    // Frame carrying 32'h5A5A_A5A5: forced to 32'h9A5A_65A5 on dut_f, flagged on dut_p.
    @(negedge clk);
    check("f13_first_pair_f", ddr_f, 2'b10);
    check("f13_first_pair_p", ddr_p, 2'b01);
    check("f13_sync_err_p", se_p, 1'b1);
    check("f13_sync_err_f", se_f, 1'b0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ddr", ddr_f, 2'b00);
    check("rst_mid_pull", pull_f, 1'b0);
    check("rst_mid_active", act_f, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1; empty = 1'b0; data = 32'hA5A5_5A5A;
    run_frame("f14_post_rst_idle", -1, -1, 32'h0, 32'h0, 32'h0, 14, 0, 0, 16);
    run_frame("f15_post_rst_word", -1, -1, 32'h0, 32'hA5A5_5A5A, 32'hA5A5_5A5A, -1, 0, 0, 16);

    en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
